// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access codes, FSM states and a
// helper that recognises legal load codes.
package lsu_pkg;

    localparam logic [2:0] LOAD_DISABLE = 3'd0;
    localparam logic [2:0] LOAD_LB      = 3'd1;
    localparam logic [2:0] LOAD_LH      = 3'd2;
    localparam logic [2:0] LOAD_LW      = 3'd3;
    localparam logic [2:0] LOAD_LBU     = 3'd4;
    localparam logic [2:0] LOAD_LHU     = 3'd5;

    localparam logic [1:0] STORE_DISABLE = 2'd0;
    localparam logic [1:0] STORE_SB      = 2'd1;
    localparam logic [1:0] STORE_SH      = 2'd2;
    localparam logic [1:0] STORE_SW      = 2'd3;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_ERR  = 2'd3
    } lsu_state_t;

    function automatic logic load_code_ok(input logic [2:0] code);
        return (code >= LOAD_LB) && (code <= LOAD_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replication, load extraction with
// sign or zero extension, and the misalignment flag for the given code.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_load,
    input  logic [1:0]  i_store,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_lane)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_wstrb    = 4'b0000;
        o_wdata    = i_sdata;
        o_ldata    = 32'd0;
        o_misalign = 1'b0;
        if (i_load != LOAD_DISABLE) begin
            case (i_load)
                LOAD_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
                LOAD_LBU: o_ldata = {24'd0, w_byte};
                LOAD_LH: begin
                    o_ldata    = {{16{w_half[15]}}, w_half};
                    o_misalign = i_lane[0];
                end
                LOAD_LHU: begin
                    o_ldata    = {16'd0, w_half};
                    o_misalign = i_lane[0];
                end
                LOAD_LW: begin
                    o_ldata    = i_rdata;
                    o_misalign = (i_lane != 2'd0);
                end
                default: o_ldata = 32'd0;
            endcase
        end else begin
            case (i_store)
                STORE_SB: begin
                    o_wdata = {4{i_sdata[7:0]}};
                    o_wstrb = 4'b0001 << i_lane;
                end
                STORE_SH: begin
                    o_wdata    = {2{i_sdata[15:0]}};
                    o_wstrb    = i_lane[1] ? 4'b1100 : 4'b0011;
                    o_misalign = i_lane[0];
                end
                STORE_SW: begin
                    o_wdata    = i_sdata;
                    o_wstrb    = 4'b1111;
                    o_misalign = (i_lane != 2'd0);
                end
                default: o_wstrb = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts decoded load/store requests, runs the valid/ready
// exchange with word-organised data memory and returns extended load data.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  is_load,
    input  logic [1:0]  is_store,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [8:0] TMO = 9'(TIMEOUT_CYCLES);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;
    logic [2:0]  r_load;
    logic [1:0]  r_store;
    logic [1:0]  r_lane;
    logic [31:0] r_sdata;
    logic [7:0]  r_cnt;
    logic        r_req_ready;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_load_data;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic        w_in_req;
    logic [1:0]  w_in_store;
    logic [2:0]  w_al_load;
    logic [1:0]  w_al_store;
    logic [1:0]  w_al_lane;
    logic [31:0] w_al_sdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;
    logic        w_misalign;
    logic [8:0]  w_cnt_inc;
    logic        w_timeout;

    // A load code masks any simultaneous store code.
    assign w_in_store = (is_load != LOAD_DISABLE) ? STORE_DISABLE : is_store;
    assign w_accept   = req_valid && r_req_ready &&
                        (load_code_ok(is_load) ||
                         ((is_load == LOAD_DISABLE) && (is_store != STORE_DISABLE)));
    assign w_in_req   = (r_state == LSU_REQ);

    // Outside REQ the lane logic evaluates the incoming request; inside REQ it
    // uses the latched access so load data is extracted from the right lane.
    assign w_al_load  = w_in_req ? r_load  : is_load;
    assign w_al_store = w_in_req ? r_store : w_in_store;
    assign w_al_lane  = w_in_req ? r_lane  : addr[1:0];
    assign w_al_sdata = w_in_req ? r_sdata : store_data;

    lsu_align u_align (
        .i_load     (w_al_load),
        .i_store    (w_al_store),
        .i_lane     (w_al_lane),
        .i_sdata    (w_al_sdata),
        .i_rdata    (mem_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata),
        .o_misalign (w_misalign)
    );

    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
    assign w_timeout = (TMO != 9'd0) && (w_cnt_inc == TMO);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LSU_REQ: begin
                if (mem_ready) begin
                    w_state_next = LSU_RESP;
                end else if (w_timeout) begin
                    w_state_next = LSU_ERR;
                end
            end
            default: begin
                if (w_accept) begin
                    w_state_next = w_misalign ? LSU_ERR : LSU_REQ;
                end else begin
                    w_state_next = LSU_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LSU_IDLE;
            r_load      <= LOAD_DISABLE;
            r_store     <= STORE_DISABLE;
            r_lane      <= 2'd0;
            r_sdata     <= 32'd0;
            r_cnt       <= 8'd0;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_load_data <= 32'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next != LSU_REQ);
            r_done      <= (w_state_next == LSU_RESP) || (w_state_next == LSU_ERR);
            r_err       <= (w_state_next == LSU_ERR);
            r_mem_req   <= (w_state_next == LSU_REQ);
            if (w_accept) begin
                r_load  <= is_load;
                r_store <= w_in_store;
                r_lane  <= addr[1:0];
                r_sdata <= store_data;
                r_cnt   <= 8'd0;
                if (!w_misalign) begin
                    r_mem_we    <= (w_in_store != STORE_DISABLE);
                    r_mem_addr  <= {addr[31:2], 2'b00};
                    r_mem_wstrb <= w_wstrb;
                    r_mem_wdata <= w_wdata;
                end
            end else if (w_in_req && !mem_ready) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_in_req && mem_ready && (r_load != LOAD_DISABLE)) begin
                r_load_data <= w_ldata;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign load_data = r_load_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;

endmodule
